cmsdk_apb4_eg_slave_ws: RTL and testbench
=========================================

# cmsdk_apb4_eg_slave_ws

APB4 example slave with a parametrised bank of 32-bit read/write data registers, programmable wait-state insertion and error responses. It is the next generation of the always-ready, always-OKAY example slave, and sits on an APB4 port of the peripheral subsystem. Software and testbenches use it to exercise PREADY stalls, PSLVERR handling and PSTRB byte lanes on the bus fabric.

## Interface
- ADDRWIDTH, 12, APB address width; minimum 12; decode uses PADDR[11:2], and upper bits are ignored.
- NUMREGS, 8, number of DATA registers; legal range 1..64.
- PCLK  in  1  clock; the block's only clock.
- PRESETn  in  1  reset; asynchronous, active-low.
- PSEL  in  1  slave select.
- PADDR  in  ADDRWIDTH  byte address.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PWDATA  in  32  write data.
- PSTRB  in  4  write byte strobes.
- PPROT  in  3  protection; present only with CMSDK_APB4_EG_SLAVE_PPROT_EN.
- ECOREVNUM  in  4  ECO revision, reflected in ID.
- PRDATA  out  32  read data; 0 except in the completing read cycle.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error; may be high only when PREADY=1.

## Operation
Register map (byte offsets):
- 0x000 + 4n, n < NUMREGS: DATA[n]. RW; PSTRB honoured per byte; reset 0.
- 0xF00 CTRL: [3:0] WAIT, reset 0; [8] ERREN, reset 1; other bits RAZ/WI.
- 0xF04 STATUS: [0] ERRFLAG, sticky, write-1-to-clear; [15:8] ERRCNT, saturates at 255, cleared together with ERRFLAG. Other bits RAZ/WI.
- 0xFE0 ID: {20'h0, ECOREVNUM, 8'hA5}. Read-only.

Error events:
- Read or write to an unmapped offset: read returns 0, write is ignored.
- Write to ID: ignored.
- Each error event sets ERRFLAG and increments ERRCNT.
- PSLVERR=1 is returned for an error event only if ERREN=1.

State machine:
- IDLE: PREADY=1. On PSEL & ~PENABLE, capture address, direction, PWDATA and PSTRB; load cnt ← CTRL.WAIT; go to ACCESS.
- ACCESS: PREADY = (cnt==0). While cnt≠0, decrement cnt each cycle. At cnt==0, perform the following, then go to IDLE; a back-to-back setup in the same cycle reloads and re-enters ACCESS:
  - commit the write on that edge;
  - drive PRDATA/PSLVERR;
  - update STATUS.
- PSEL deasserted while in ACCESS is a protocol violation: return to IDLE with no commit and no STATUS update.

Write rules:
- A CTRL write takes effect from the next transfer; the current transfer's wait count is unaffected.
- A STATUS write with PSTRB[0]=1 and PWDATA[0]=1 clears ERRFLAG and ERRCNT.
- PSTRB is ignored on reads.

## Timing
- Reset values: PRDATA=0, PREADY=1, PSLVERR=0, FSM=IDLE, cnt=0, and all registers at their reset values.
- Access phase lasts WAIT+1 cycles, so a transfer is 2+WAIT cycles including setup.
- Read data reflects register contents at the completing cycle.
- Asserting PRESETn mid-transfer aborts the transfer immediately: outputs return to reset values and no write is committed.
- ERRCNT at 255 plus another error stays at 255, and ERRFLAG stays 1.

## Configuration
- CMSDK_APB4_EG_SLAVE_PPROT_EN defined: PPROT port exists. A write to CTRL or STATUS with PPROT[0]=0 (unprivileged):
  - is ignored;
  - counts as an error event.
  
  DATA and ID accesses are unaffected.
- Macro undefined: PPROT port absent, and all accesses are treated as privileged.

## Structure
- Package cmsdk_apb4_eg_slave_ws_pkg contains:
  - offset constants (DATA base, CTRL, STATUS, ID);
  - ID low byte 8'hA5;
  - CTRL/STATUS field positions;
  - FSM state enum.
- Sub-module cmsdk_apb4_eg_slave_ws_fsm contains the IDLE/ACCESS FSM, wait counter and captured transfer attributes. The top level holds the register bank, decode, error logic and read mux.

## Test plan
- Reset then read ID with ECOREVNUM=4'h3 → PRDATA=32'h0000_03A5, PREADY=1 in the first access cycle, PSLVERR=0.
- CTRL.WAIT=3; write DATA[2]=32'hDEAD_BEEF with PSTRB=4'b0101 → PREADY low for 3 access cycles and high on the 4th; readback = 32'h00AD_00EF.
- Write 0xF00 to unmapped offset 0x800, ERREN=1 → PSLVERR=1 at completion, STATUS=32'h0000_0101; after CTRL.ERREN=0, same access → PSLVERR=0, STATUS=32'h0000_0201.
- 256 unmapped reads → ERRCNT=255; write STATUS=1 → STATUS=0.
- PRESETn low during a write's second wait cycle (WAIT=5) → PREADY=1 and PRDATA=0 immediately; target DATA register is still 0 after reset release.
- With PPROT_EN: CTRL write with PPROT=3'b000 → CTRL unchanged, PSLVERR=1; same write with PPROT=3'b001 → CTRL updated, PSLVERR=0.

Source files
------------

// File: rtl/cmsdk_apb4_eg_slave_ws_pkg.sv
// cmsdk_apb4_eg_slave_ws_pkg
//   Shared definitions for the APB4 wait-state example slave:
//   - register byte offsets and their word indices (PADDR[11:2])
//   - ID register low byte
//   - CTRL / STATUS field positions
//   - IDLE/ACCESS state encoding
package cmsdk_apb4_eg_slave_ws_pkg;

  localparam logic [11:0] DATA_BASE_OFS = 12'h000;
  localparam logic [11:0] CTRL_OFS      = 12'hF00;
  localparam logic [11:0] STATUS_OFS    = 12'hF04;
  localparam logic [11:0] ID_OFS        = 12'hFE0;

  localparam logic [9:0]  DATA_BASE_IDX = DATA_BASE_OFS[11:2];
  localparam logic [9:0]  CTRL_IDX      = CTRL_OFS[11:2];
  localparam logic [9:0]  STATUS_IDX    = STATUS_OFS[11:2];
  localparam logic [9:0]  ID_IDX        = ID_OFS[11:2];

  localparam logic [7:0]  ID_LOW_BYTE   = 8'hA5;

  localparam int CTRL_WAIT_LSB      = 0;
  localparam int CTRL_WAIT_W        = 4;
  localparam int CTRL_ERREN_BIT     = 8;
  localparam int STATUS_ERRFLAG_BIT = 0;
  localparam int STATUS_ERRCNT_LSB  = 8;
  localparam int STATUS_ERRCNT_W    = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/cmsdk_apb4_eg_slave_ws_fsm.sv
// cmsdk_apb4_eg_slave_ws_fsm
//   IDLE/ACCESS transfer sequencer with programmable wait counter. Captures
//   the transfer attributes in the setup cycle and flags the completing
//   access cycle to the register bank.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   psel, penable     APB phase controls
//   pwrite, pidx      direction and word index (PADDR[11:2])
//   pwdata, pstrb     write data and byte strobes
//   ppriv             privileged access (PPROT[0], or 1 when not configured)
//   wait_cfg          CTRL.WAIT, sampled at setup
//   pready            APB PREADY
//   complete          completing access cycle (commit / respond this cycle)
//   xfer_*            attributes captured at setup
module cmsdk_apb4_eg_slave_ws_fsm
  import cmsdk_apb4_eg_slave_ws_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [9:0]  pidx,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  input  logic        ppriv,
  input  logic [3:0]  wait_cfg,
  output logic        pready,
  output logic        complete,
  output logic        xfer_write,
  output logic [9:0]  xfer_idx,
  output logic [31:0] xfer_wdata,
  output logic [3:0]  xfer_strb,
  output logic        xfer_priv
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [9:0]  idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        priv_q;
  logic        capture;
  logic        setup;

  assign setup = psel & ~penable;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pready   = 1'b1;
    complete = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (setup) begin
          capture = 1'b1;
        end
      end
      ST_ACCESS: begin
        pready = (cnt_q == 4'd0);
        if (!psel) begin
          // Master abandoned the transfer: drop it silently.
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = ST_IDLE;
          if (setup) begin
            capture = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (capture) begin
      state_d = ST_ACCESS;
      cnt_d   = wait_cfg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Transfer attributes are only consumed while complete=1, so they carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      write_q <= pwrite;
      idx_q   <= pidx;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      priv_q  <= ppriv;
    end
  end

  assign xfer_write = write_q;
  assign xfer_idx   = idx_q;
  assign xfer_wdata = wdata_q;
  assign xfer_strb  = strb_q;
  assign xfer_priv  = priv_q;

endmodule

// File: rtl/cmsdk_apb4_eg_slave_ws.sv
// cmsdk_apb4_eg_slave_ws
//   APB4 example slave: NUMREGS x 32-bit data registers, CTRL (wait states,
//   error enable), STATUS (sticky error flag + saturating error count), ID.
//   Optional macro CMSDK_APB4_EG_SLAVE_PPROT_EN adds the PPROT port; then
//   unprivileged writes to CTRL/STATUS are dropped and counted as errors.
// Ports:
//   PCLK, PRESETn                 clock, asynchronous active-low reset
//   PSEL, PADDR, PENABLE, PWRITE  APB4 request
//   PWDATA, PSTRB                 write data, byte strobes
//   PPROT                         protection (only with the macro defined)
//   ECOREVNUM                     ECO revision, reflected in ID
//   PRDATA, PREADY, PSLVERR       APB4 response
module cmsdk_apb4_eg_slave_ws
  import cmsdk_apb4_eg_slave_ws_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int NUMREGS   = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [31:0]          PWDATA,
  input  logic [3:0]           PSTRB,
`ifdef CMSDK_APB4_EG_SLAVE_PPROT_EN
  input  logic [2:0]           PPROT,
`endif
  input  logic [3:0]           ECOREVNUM,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR
);

  logic        ppriv;
  logic        complete;
  logic        xfer_write;
  logic [9:0]  xfer_idx;
  logic [31:0] xfer_wdata;
  logic [3:0]  xfer_strb;
  logic        xfer_priv;

  logic [31:0] data_q [NUMREGS];
  logic [31:0] data_d [NUMREGS];
  logic [CTRL_WAIT_W-1:0]     wait_q, wait_d;
  logic                       erren_q, erren_d;
  logic                       errflag_q, errflag_d;
  logic [STATUS_ERRCNT_W-1:0] errcnt_q, errcnt_d;

  logic        is_data, is_ctrl, is_status, is_id;
  logic        priv_viol, err_event, wr_ok;
  logic [31:0] rd_mux;

  logic unused_addr;
  generate
    if (ADDRWIDTH > 12) begin : g_wide_addr
      assign unused_addr = ^{PADDR[ADDRWIDTH-1:12], PADDR[1:0]};
    end else begin : g_narrow_addr
      assign unused_addr = ^PADDR[1:0];
    end
  endgenerate

`ifdef CMSDK_APB4_EG_SLAVE_PPROT_EN
  logic unused_pprot;
  assign unused_pprot = ^PPROT[2:1];
  assign ppriv        = PPROT[0];
`else
  assign ppriv = 1'b1;
`endif

  function automatic logic [STATUS_ERRCNT_W-1:0] sat_inc(input logic [STATUS_ERRCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  cmsdk_apb4_eg_slave_ws_fsm u_fsm (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .psel       (PSEL),
    .penable    (PENABLE),
    .pwrite     (PWRITE),
    .pidx       (PADDR[11:2]),
    .pwdata     (PWDATA),
    .pstrb      (PSTRB),
    .ppriv      (ppriv),
    .wait_cfg   (wait_q),
    .pready     (PREADY),
    .complete   (complete),
    .xfer_write (xfer_write),
    .xfer_idx   (xfer_idx),
    .xfer_wdata (xfer_wdata),
    .xfer_strb  (xfer_strb),
    .xfer_priv  (xfer_priv)
  );

  // Decode is done on the captured index, so it is stable across wait states.
  assign is_data   = (xfer_idx >= DATA_BASE_IDX) && (xfer_idx < 10'(NUMREGS));
  assign is_ctrl   = (xfer_idx == CTRL_IDX);
  assign is_status = (xfer_idx == STATUS_IDX);
  assign is_id     = (xfer_idx == ID_IDX);

  assign priv_viol = xfer_write & (is_ctrl | is_status) & ~xfer_priv;
  assign err_event = ~(is_data | is_ctrl | is_status | is_id)
                   | (xfer_write & is_id)
                   | priv_viol;
  assign wr_ok     = complete & xfer_write & ~err_event;

  always_comb begin
    rd_mux = 32'h0;
    for (int i = 0; i < NUMREGS; i++) begin
      if (xfer_idx == 10'(i)) rd_mux = data_q[i];
    end
    if (is_ctrl) begin
      rd_mux[CTRL_WAIT_LSB +: CTRL_WAIT_W] = wait_q;
      rd_mux[CTRL_ERREN_BIT]               = erren_q;
    end
    if (is_status) begin
      rd_mux[STATUS_ERRFLAG_BIT]                    = errflag_q;
      rd_mux[STATUS_ERRCNT_LSB +: STATUS_ERRCNT_W] = errcnt_q;
    end
    if (is_id) rd_mux = {20'h0, ECOREVNUM, ID_LOW_BYTE};
  end

  assign PRDATA  = (complete & ~xfer_write) ? rd_mux : 32'h0;
  assign PSLVERR = complete & err_event & erren_q;

  always_comb begin
    data_d    = data_q;
    wait_d    = wait_q;
    erren_d   = erren_q;
    errflag_d = errflag_q;
    errcnt_d  = errcnt_q;
    if (wr_ok) begin
      for (int i = 0; i < NUMREGS; i++) begin
        if (xfer_idx == 10'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (xfer_strb[b]) data_d[i][8*b +: 8] = xfer_wdata[8*b +: 8];
          end
        end
      end
      if (is_ctrl) begin
        if (xfer_strb[0]) wait_d  = xfer_wdata[CTRL_WAIT_LSB +: CTRL_WAIT_W];
        if (xfer_strb[1]) erren_d = xfer_wdata[CTRL_ERREN_BIT];
      end
      if (is_status && xfer_strb[0] && xfer_wdata[STATUS_ERRFLAG_BIT]) begin
        errflag_d = 1'b0;
        errcnt_d  = '0;
      end
    end
    // A STATUS clear is never itself an error, so the two updates cannot collide.
    if (complete && err_event) begin
      errflag_d = 1'b1;
      errcnt_d  = sat_inc(errcnt_q);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUMREGS; i++) data_q[i] <= 32'h0;
      wait_q    <= '0;
      erren_q   <= 1'b1;
      errflag_q <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      data_q    <= data_d;
      wait_q    <= wait_d;
      erren_q   <= erren_d;
      errflag_q <= errflag_d;
      errcnt_q  <= errcnt_d;
    end
  end

endmodule

// File: tb/tb_cmsdk_apb4_eg_slave_ws.sv
module tb_cmsdk_apb4_eg_slave_ws;

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic [11:0] paddr;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
`ifdef CMSDK_APB4_EG_SLAVE_PPROT_EN
  logic [2:0]  pprot;
`endif
  logic [3:0]  ecorevnum;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int vectors;
  int miscompares;

  logic [31:0] rd;
  logic        er;
  int          w;

  cmsdk_apb4_eg_slave_ws #(.ADDRWIDTH(12), .NUMREGS(8)) dut (
    .PCLK      (clk),
    .PRESETn   (rst_n),
    .PSEL      (psel),
    .PADDR     (paddr),
    .PENABLE   (penable),
    .PWRITE    (pwrite),
    .PWDATA    (pwdata),
    .PSTRB     (pstrb),
`ifdef CMSDK_APB4_EG_SLAVE_PPROT_EN
    .PPROT     (pprot),
`endif
    .ECOREVNUM (ecorevnum),
    .PRDATA    (prdata),
    .PREADY    (pready),
    .PSLVERR   (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer; signals are driven and sampled 1ns after the clock edge.
  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, output logic [31:0] rdata,
                     output logic err, output int waits);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (pready !== 1'b1 && waits < 64) begin
      waits++;
      @(posedge clk); #1;
    end
    check("pready_bound", {31'h0, pready}, 32'h1);
    rdata = prdata;
    err   = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pwdata = 32'h0; pstrb = 4'h0; ecorevnum = 4'h3;
`ifdef CMSDK_APB4_EG_SLAVE_PPROT_EN
    pprot = 3'b001;
`endif
    #2;
    check("rst_pready",  {31'h0, pready},  32'h1);
    check("rst_prdata",  prdata,           32'h0);
    check("rst_pslverr", {31'h0, pslverr}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    apb(1'b0, 12'hFE0, 32'h0, 4'h0, rd, er, w);
    check("id_read", rd, 32'h0000_03A5);
    check("id_err", {31'h0, er}, 32'h0);
    check("id_waits", w, 0);
    apb(1'b0, 12'hF00, 32'h0, 4'h0, rd, er, w);
    check("ctrl_reset", rd, 32'h0000_0100);
    apb(1'b0, 12'hF04, 32'h0, 4'h0, rd, er, w);
    check("status_reset", rd, 32'h0);

    apb(1'b1, 12'hF00, 32'h0000_0103, 4'hF, rd, er, w);
    check("ctrl_wr_waits", w, 0);
    apb(1'b1, 12'h008, 32'hDEAD_BEEF, 4'b0101, rd, er, w);
    check("data2_wr_waits", w, 3);
    check("data2_wr_err", {31'h0, er}, 32'h0);
    apb(1'b0, 12'h008, 32'h0, 4'h0, rd, er, w);
    check("data2_strb_rd", rd, 32'h00AD_00EF);
    check("data2_rd_waits", w, 3);
    apb(1'b1, 12'h01C, 32'hA5A5_5A5A, 4'hF, rd, er, w);
    apb(1'b0, 12'h01C, 32'h0, 4'hF, rd, er, w);
    check("data7_rd", rd, 32'hA5A5_5A5A);

    apb(1'b1, 12'hF00, 32'h0000_0100, 4'hF, rd, er, w);
    check("ctrl_old_wait", w, 3);
    apb(1'b1, 12'h800, 32'h0000_0F00, 4'hF, rd, er, w);
    check("unmapped_wr_err1", {31'h0, er}, 32'h1);
    check("unmapped_wr_waits", w, 0);
    apb(1'b0, 12'hF04, 32'h0, 4'h0, rd, er, w);
    check("status_1err", rd, 32'h0000_0101);
    apb(1'b1, 12'hF00, 32'h0000_0000, 4'hF, rd, er, w);
    apb(1'b1, 12'h800, 32'h0000_0F00, 4'hF, rd, er, w);
    check("unmapped_wr_err0", {31'h0, er}, 32'h0);
    apb(1'b0, 12'hF04, 32'h0, 4'h0, rd, er, w);
    check("status_2err", rd, 32'h0000_0201);
    apb(1'b0, 12'h020, 32'h0, 4'h0, rd, er, w);
    check("data_past_end_rd", rd, 32'h0);
    apb(1'b1, 12'hFE0, 32'hFFFF_FFFF, 4'hF, rd, er, w);
    apb(1'b0, 12'hFE0, 32'h0, 4'h0, rd, er, w);
    check("id_after_wr", rd, 32'h0000_03A5);
    apb(1'b0, 12'hF04, 32'h0, 4'h0, rd, er, w);
    check("status_4err", rd, 32'h0000_0401);
    apb(1'b1, 12'hF04, 32'h0000_0001, 4'b1110, rd, er, w);
    apb(1'b0, 12'hF04, 32'h0, 4'h0, rd, er, w);
    check("status_noclr_strb", rd, 32'h0000_0401);
    apb(1'b1, 12'hF04, 32'h0000_0001, 4'b0001, rd, er, w);
    apb(1'b0, 12'hF04, 32'h0, 4'h0, rd, er, w);
    check("status_clr", rd, 32'h0);

    apb(1'b1, 12'hF00, 32'hFFFF_FFFF, 4'hF, rd, er, w);
    apb(1'b0, 12'hF00, 32'h0, 4'h0, rd, er, w);
    check("ctrl_raz", rd, 32'h0000_010F);
    check("ctrl_wait15", w, 15);
    apb(1'b1, 12'hF00, 32'h0000_0000, 4'hF, rd, er, w);

    for (int i = 0; i < 256; i++) apb(1'b0, 12'h900, 32'h0, 4'h0, rd, er, w);
    check("unmapped_rd_data", rd, 32'h0);
    apb(1'b0, 12'hF04, 32'h0, 4'h0, rd, er, w);
    check("errcnt_255", rd, 32'h0000_FF01);
    apb(1'b0, 12'h900, 32'h0, 4'h0, rd, er, w);
    apb(1'b0, 12'hF04, 32'h0, 4'h0, rd, er, w);
    check("errcnt_sat", rd, 32'h0000_FF01);
    apb(1'b1, 12'hF04, 32'h0000_0001, 4'hF, rd, er, w);
    apb(1'b0, 12'hF04, 32'h0, 4'h0, rd, er, w);
    check("status_clr_sat", rd, 32'h0);

    apb(1'b1, 12'hF00, 32'h0000_0105, 4'hF, rd, er, w);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010;
    pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    check("abort_wait1", {31'h0, pready}, 32'h0);
    @(posedge clk); #1;
    check("abort_wait2", {31'h0, pready}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pready", {31'h0, pready}, 32'h1);
    check("abort_prdata", prdata, 32'h0);
    check("abort_pslverr", {31'h0, pslverr}, 32'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    apb(1'b0, 12'h010, 32'h0, 4'h0, rd, er, w);
    check("abort_no_commit", rd, 32'h0);
    apb(1'b0, 12'hF00, 32'h0, 4'h0, rd, er, w);
    check("abort_ctrl_reset", rd, 32'h0000_0100);

`ifdef CMSDK_APB4_EG_SLAVE_PPROT_EN
    pprot = 3'b000;
    apb(1'b1, 12'hF00, 32'h0000_0103, 4'hF, rd, er, w);
    check("pprot_unpriv_err", {31'h0, er}, 32'h1);
    apb(1'b0, 12'hF00, 32'h0, 4'h0, rd, er, w);
    check("pprot_ctrl_kept", rd, 32'h0000_0100);
    pprot = 3'b001;
    apb(1'b1, 12'hF00, 32'h0000_0103, 4'hF, rd, er, w);
    check("pprot_priv_err", {31'h0, er}, 32'h0);
    apb(1'b0, 12'hF00, 32'h0, 4'h0, rd, er, w);
    check("pprot_ctrl_upd", rd, 32'h0000_0103);
    apb(1'b0, 12'hF04, 32'h0, 4'h0, rd, er, w);
    check("pprot_status", rd, 32'h0000_0101);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
